unidade_controle_multiciclo: RTL and testbench
==============================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 SHALL have ports: clk in 1, single clock, all state updates on rising edge; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: OP in 6, opcode from instruction register; Funct in 6, function field from instruction register.
REQ-003 SHALL have ports: Zero in 1, ULA zero flag; mem_ready in 1, memory completes access this cycle.
REQ-004 SHALL have ports: mem_req out 1; IorD out 1; IRWrite out 1; PCWrite out 1; PCEn out 1, PC load = PCWrite | (Branch & Zero); Branch out 1.
REQ-005 SHALL have ports: PCSrc out 2, 00 ULA result, 01 ULAOut reg, 10 jump target; ULASrcA out 1, 0 PC, 1 reg A; ULASrcB out 2, 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-006 SHALL have ports: ULA_Control out 3; RegWrite out 1; RegDst out 1; MemtoReg out 1; MemWrite out 1; estado out 4, current state code.

Function
REQ-007 SHALL be a Moore FSM, state register 4 bits, outputs decoded from state plus mem_ready/Zero only as stated.
REQ-008 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL go to FETCH next cycle with all enables 0.
REQ-009 Every output not listed for a state SHALL be 0; ULA_Control default SHALL be 010.
REQ-010 FETCH: mem_req=1, IorD=0, ULASrcA=0, ULASrcB=01, ULA_Control=010, PCSrc=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, go DECODE when mem_ready=1.
REQ-011 DECODE: ULASrcA=0, ULASrcB=11, ULA_Control=010; next: OP 100011/101011 -> MEMADR; 000000 with Funct in {100000,100010,100100,100101,101010} -> EXEC; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP; anything else -> FETCH.
REQ-012 MEMADR: ULASrcA=1, ULASrcB=10, ULA_Control=010; next MEMRD if OP=100011, else MEMWR.
REQ-013 MEMRD: mem_req=1, IorD=1; stay until mem_ready=1, then MEMWB.
REQ-014 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-015 MEMWR: mem_req=1, IorD=1, MemWrite=1 held every cycle in state; stay until mem_ready=1, then FETCH.
REQ-016 EXEC: ULASrcA=1, ULASrcB=00, ULA_Control from Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; next ALUWB.
REQ-017 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-018 BEQ: ULASrcA=1, ULASrcB=00, ULA_Control=110, Branch=1, PCSrc=01; PCEn=Zero; next FETCH.
REQ-019 ADDIEX: ULASrcA=1, ULASrcB=10, ULA_Control=010; next ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-020 JUMP: PCWrite=1, PCSrc=10; next FETCH.
REQ-021 Latency in cycles with mem_ready=1 on first request: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2; each mem_ready=0 cycle adds one.
REQ-022 OP/Funct SHALL be sampled only in DECODE (and EXEC/MEMADR for decode of ULA_Control/next state); changes elsewhere SHALL have no effect.
REQ-023 mem_ready SHALL be ignored in states without mem_req=1.

Reset
REQ-024 rst_n=0 SHALL immediately force state to FETCH, independent of clk.
REQ-025 While rst_n=0, IRWrite, PCWrite, PCEn, MemWrite, RegWrite, Branch, mem_req SHALL be 0; other outputs SHALL take FETCH values (IorD=0, ULASrcA=0, ULASrcB=01, ULA_Control=010, PCSrc=00, estado=0).
REQ-026 Reset mid-instruction (e.g. in MEMWR) SHALL deassert MemWrite in the same cycle, and the first edge after release SHALL evaluate FETCH.

Verification
REQ-027 Reset release, OP=100011, mem_ready=1 -> estado 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-028 OP=101011, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then estado=0.
REQ-029 OP=000000, Funct=101010 -> EXEC with ULA_Control=111, ALUWB with RegWrite=1, RegDst=1.
REQ-030 OP=000100, Zero=1 -> PCEn=1 in BEQ; repeat with Zero=0 -> PCEn=0.
REQ-031 OP=111111 and OP=000000/Funct=000000 -> DECODE then FETCH, no write enable asserted.
REQ-032 rst_n pulled low in MEMRD between edges -> estado=0, mem_req=0 immediately; normal fetch after release.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Moore control unit for a multicycle MIPS-like datapath.
//               Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
//               Memory accesses stall in place until mem_ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCEn,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [2:0] ULA_Control,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t state;
    state_t next_state;
    logic   funct_ok;

    // Only the five supported R-type functions are allowed into EXEC.
    assign funct_ok = (Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND)
                   || (Funct == FN_OR)  || (Funct == FN_SLT);

    // State register; reset drops straight to FETCH without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; reset gates every enable low.
    always_comb begin
        next_state  = FETCH;
        mem_req     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        PCSrc       = 2'b00;
        ULASrcA     = 1'b0;
        ULASrcB     = 2'b00;
        ULA_Control = 3'b010;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;

        case (state)
            FETCH: begin
                mem_req     = 1'b1;
                ULASrcB     = 2'b01;
                IRWrite     = mem_ready;
                PCWrite     = mem_ready;
                next_state  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ULASrcB = 2'b11;
                case (OP)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = funct_ok ? EXEC : FETCH;
                    OP_BEQ:       next_state = BEQ;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                ULASrcA    = 1'b1;
                ULASrcB    = 2'b10;
                next_state = (OP == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ULASrcA = 1'b1;
                case (Funct)
                    FN_SUB:  ULA_Control = 3'b110;
                    FN_AND:  ULA_Control = 3'b000;
                    FN_OR:   ULA_Control = 3'b001;
                    FN_SLT:  ULA_Control = 3'b111;
                    default: ULA_Control = 3'b010;
                endcase
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQ: begin
                ULASrcA     = 1'b1;
                ULA_Control = 3'b110;
                Branch      = 1'b1;
                PCSrc       = 2'b01;
            end
            ADDIEX: begin
                ULASrcA    = 1'b1;
                ULASrcB    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // While held in reset the state is already FETCH; suppress its enables.
        if (!rst_n) begin
            mem_req     = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            Branch      = 1'b0;
            PCSrc       = 2'b00;
            ULASrcA     = 1'b0;
            ULASrcB     = 2'b01;
            ULA_Control = 3'b010;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            MemWrite    = 1'b0;
        end
    end

    assign PCEn   = PCWrite | (Branch & Zero);
    assign estado = state;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Scoreboard bench for the multicycle control unit. The driver
//               pushes the hand-written expected output word for each cycle;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, IorD, IRWrite, PCWrite, PCEn, Branch;
    logic [1:0] PCSrc, ULASrcB;
    logic       ULASrcA;
    logic [2:0] ULA_Control;
    logic       RegWrite, RegDst, MemtoReg, MemWrite;
    logic [3:0] estado;

    unidade_controle_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCEn(PCEn), .Branch(Branch),
        .PCSrc(PCSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
        .ULA_Control(ULA_Control), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .estado(estado)
    );

    always #5 clk = ~clk;

    // Word layout: estado, mem_req, IorD, IRWrite, PCWrite, PCEn, Branch,
    // PCSrc, ULASrcA, ULASrcB, ULA_Control, RegWrite, RegDst, MemtoReg, MemWrite
    logic [21:0] q_val[$];
    string       q_tag[$];
    int          checks = 0;
    int          passed = 0;

    function automatic logic [21:0] e_reset();
        return {4'd0, 6'b000000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_fetch(input logic mr);
        return {4'd0, 1'b1, 1'b0, mr, mr, mr, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_decode();
        return {4'd1, 6'b000000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_memadr();
        return {4'd2, 6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_memrd();
        return {4'd3, 6'b110000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_memwb();
        return {4'd4, 6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b1010};
    endfunction
    function automatic logic [21:0] e_memwr();
        return {4'd5, 6'b110000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0001};
    endfunction
    function automatic logic [21:0] e_exec(input logic [2:0] alu);
        return {4'd6, 6'b000000, 2'b00, 1'b1, 2'b00, alu, 4'b0000};
    endfunction
    function automatic logic [21:0] e_aluwb();
        return {4'd7, 6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b1100};
    endfunction
    function automatic logic [21:0] e_beq(input logic z);
        return {4'd8, 4'b0000, z, 1'b1, 2'b01, 1'b1, 2'b00, 3'b110, 4'b0000};
    endfunction
    function automatic logic [21:0] e_addiex();
        return {4'd9, 6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
    endfunction
    function automatic logic [21:0] e_addiwb();
        return {4'd10, 6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b1000};
    endfunction
    function automatic logic [21:0] e_jump();
        return {4'd11, 6'b000110, 2'b10, 1'b0, 2'b00, 3'b010, 4'b0000};
    endfunction

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic step(input logic [21:0] e, input string tag);
        q_val.push_back(e);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT output word against the oldest expectation.
    always @(negedge clk) begin
        if (q_val.size() > 0) begin
            logic [21:0] exp_v;
            logic [21:0] act_v;
            string       tag;
            exp_v = q_val.pop_front();
            tag   = q_tag.pop_front();
            act_v = {estado, mem_req, IorD, IRWrite, PCWrite, PCEn, Branch, PCSrc,
                     ULASrcA, ULASrcB, ULA_Control, RegWrite, RegDst, MemtoReg, MemWrite};
            checks++;
            if (act_v === exp_v) passed++;
            else $display("FAIL %s: got %06h (estado=%0d) expected %06h (estado=%0d)",
                          tag, act_v, act_v[21:18], exp_v, exp_v[21:18]);
        end
    end

    logic [5:0] fn_tab [5];
    logic [2:0] alu_tab[5];

    initial begin
        fn_tab[0] = 6'b101010; alu_tab[0] = 3'b111;
        fn_tab[1] = 6'b100010; alu_tab[1] = 3'b110;
        fn_tab[2] = 6'b100100; alu_tab[2] = 3'b000;
        fn_tab[3] = 6'b100101; alu_tab[3] = 3'b001;
        fn_tab[4] = 6'b100000; alu_tab[4] = 3'b010;

        rst_n = 1'b0; OP = 6'b100011; Funct = 6'b0; Zero = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        step(e_reset(), "reset_hold0");
        step(e_reset(), "reset_hold1");

        // lw, no stall: 0,1,2,3,4,0
        rst_n = 1'b1; Zero = 1'b0;
        step(e_fetch(1'b1), "lw_fetch");
        step(e_decode(),    "lw_decode");
        step(e_memadr(),    "lw_memadr");
        step(e_memrd(),     "lw_memrd");
        OP = 6'b111111;
        step(e_memwb(),     "lw_memwb");

        // sw with three stall cycles in MEMWR; mem_ready ignored in DECODE/MEMADR
        OP = 6'b101011;
        step(e_fetch(1'b1), "sw_fetch");
        mem_ready = 1'b0;
        step(e_decode(),    "sw_decode");
        step(e_memadr(),    "sw_memadr");
        for (int i = 0; i < 3; i++) step(e_memwr(), "sw_memwr_stall");
        mem_ready = 1'b1;
        step(e_memwr(),     "sw_memwr_done");

        // FETCH stall
        mem_ready = 1'b0;
        step(e_fetch(1'b0), "fetch_stall");
        mem_ready = 1'b1;

        // R-type, all five functions
        OP = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            Funct = fn_tab[k];
            step(e_fetch(1'b1),      "r_fetch");
            step(e_decode(),         "r_decode");
            step(e_exec(alu_tab[k]), "r_exec");
            step(e_aluwb(),          "r_aluwb");
        end

        // beq taken then not taken
        OP = 6'b000100; Zero = 1'b1;
        step(e_fetch(1'b1), "beq1_fetch");
        step(e_decode(),    "beq1_decode");
        step(e_beq(1'b1),   "beq_taken");
        Zero = 1'b0;
        step(e_fetch(1'b1), "beq0_fetch");
        step(e_decode(),    "beq0_decode");
        step(e_beq(1'b0),   "beq_not_taken");

        // addi
        OP = 6'b001000;
        step(e_fetch(1'b1), "addi_fetch");
        step(e_decode(),    "addi_decode");
        step(e_addiex(),    "addi_ex");
        step(e_addiwb(),    "addi_wb");

        // jump
        OP = 6'b000010;
        step(e_fetch(1'b1), "j_fetch");
        step(e_decode(),    "j_decode");
        step(e_jump(),      "j_jump");

        // unsupported opcode and unsupported R-type function
        OP = 6'b111111;
        step(e_fetch(1'b1), "bad_op_fetch");
        step(e_decode(),    "bad_op_decode");
        OP = 6'b000000; Funct = 6'b000000;
        step(e_fetch(1'b1), "bad_fn_fetch");
        step(e_decode(),    "bad_fn_decode");

        // Reset asserted between edges while stalled in MEMRD
        OP = 6'b100011;
        step(e_fetch(1'b1), "rst_rd_fetch");
        step(e_decode(),    "rst_rd_decode");
        mem_ready = 1'b0;
        step(e_memadr(),    "rst_rd_memadr");
        step(e_memrd(),     "rst_rd_memrd");
        rst_n = 1'b0;
        step(e_reset(),     "rst_in_memrd");
        rst_n = 1'b1; mem_ready = 1'b1;
        step(e_fetch(1'b1), "rst_rd_refetch");
        step(e_decode(),    "rst_rd_redecode");

        // Reset asserted between edges while stalled in MEMWR
        OP = 6'b101011; mem_ready = 1'b0;
        step(e_memadr(),    "rst_wr_memadr");
        step(e_memwr(),     "rst_wr_memwr");
        rst_n = 1'b0;
        step(e_reset(),     "rst_in_memwr");
        rst_n = 1'b1;
        step(e_fetch(1'b0), "rst_wr_refetch");

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 10 && q_val.size() > 0; t++) @(posedge clk);
        if (q_val.size() > 0) begin
            $display("FAIL drain: %0d entries left, expected 0", q_val.size());
            checks++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
